reg_file_rename: RTL and testbench
==================================

// Module: reg_file_rename
// PURPOSE
//  Architectural register file plus per-register rename tags (Q). Sits downstream of the reorder buffer:
//  it consumes ROB commits (rd, result, ROB id) and serves operand reads and renames from the dispatcher.
//  A tag of 0 means "value valid"; ROB ids are 1..ROB_SIZE-1 (slot 0 unused). Flush clears all tags.
// PARAMETERS
//  XLEN       32  data width
//  REG_NUM    32  number of architectural registers (x0 hardwired zero)
//  ROB_IDX_W  5   width of ROB id / rename tag
// PORTS
//  clk            in   1          clock, all state updates on posedge
//  rst_n          in   1          reset, synchronous, active-low
//  rdy            in   1          global enable; low = hold all state
//  flush          in   1          mispredict flush (ROB wrong_commit)
//  commit_valid   in   1          ROB commit this cycle
//  commit_rd      in   5          committed destination register
//  commit_res     in   XLEN       committed value
//  commit_dep     in   ROB_IDX_W  ROB id of committing entry
//  rename_valid   in   1          dispatcher allocates rd this cycle
//  rename_rd      in   5          destination being renamed
//  rename_rob_id  in   ROB_IDX_W  ROB id allocated (ROB next_tail)
//  rs1, rs2       in   5          source register indices
//  val1, val2     out  XLEN       source values (comb.)
//  q1, q2         out  ROB_IDX_W  source tags, 0 = value ready (comb.)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): all regs <= 0, all tags <= 0. Overrides rdy and flush.
//  - rdy=0: no state change; read ports still valid combinationally.
//  - Commit (commit_valid & rdy & commit_rd!=0): reg[commit_rd] <= commit_res unconditionally;
//    tag[commit_rd] <= 0 only if tag[commit_rd]==commit_dep (younger rename survives).
//  - Rename (rename_valid & rdy & rename_rd!=0 & !flush): tag[rename_rd] <= rename_rob_id.
//  - Same reg commit+rename same cycle: value written, tag = rename_rob_id (rename wins).
//  - Flush: all tags <= 0; rename ignored; a commit in the same cycle IS applied
//    (ROB raises commit_valid together with wrong_commit for the mispredicted branch's rd).
//  - x0: never written, tag never set; reads give val=0, q=0.
//  - Read (1-cycle 0 latency, comb.): default val=reg[rs], q=tag[rs].
//    Commit bypass: if commit_valid & commit_rd==rs!=0 & tag[rs]==commit_dep -> val=commit_res, q=0.
//    No rename bypass: reads see mapping before this cycle's rename (instr with rs==rd sees old tag).
//  - Reads during flush cycle return pre-flush tags; dispatcher discards them.
//  - No handshake/backpressure; ROB-full gating is the dispatcher's job.
// STRUCTURE
//  - Shared package/const_def: XLEN, REG_NUM, ROB_IDX_W, TAG_NONE=0.
//  - One sub-module natural: rf_read_port (bypass mux), instantiated twice for rs1/rs2.
//  - State: reg array [REG_NUM][XLEN], tag array [REG_NUM][ROB_IDX_W]; one always block for update.
// TESTING
//  - Reset then read rs1=5,rs2=0 -> val=0,q=0 both; write x0 via commit 0xDEAD -> x0 still 0.
//  - Rename x3->ROB 4; next cycle rs1=3 -> q1=4; commit rd=3 res=0x1234 dep=4 -> same cycle val1=0x1234,q1=0; after -> tag 0.
//  - Rename x7->2, then x7->6; commit rd=7 dep=2 res=9 -> reg[7]=9, q stays 6.
//  - Same cycle commit rd=8 dep=3 and rename rd=8 id=5 (tag was 3) -> reg[8]=commit_res, tag[8]=5.
//  - Tags x1..x4 set, then flush+commit rd=1 res=0x40 -> reg[1]=0x40, all tags 0, concurrent rename ignored.
//  - rdy=0 with commit/rename asserted -> no change; rst_n=0 mid-traffic -> all zero next cycle.

Source files
------------

// File: rtl/reg_file_rename_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_rename_pkg
// Description : Shared widths and constants for the renamed register file.
//               XLEN      - data width
//               REG_NUM   - architectural register count (x0 hardwired zero)
//               REG_IDX_W - register index width
//               ROB_IDX_W - ROB id / rename tag width
//               TAG_NONE  - tag value meaning "register value is valid"
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_rename_pkg;

    localparam int XLEN      = 32;
    localparam int REG_NUM   = 32;
    localparam int REG_IDX_W = 5;
    localparam int ROB_IDX_W = 5;

    localparam logic [ROB_IDX_W-1:0] TAG_NONE = '0;

endpackage : reg_file_rename_pkg
`default_nettype wire

// File: rtl/reg_file_rename_rf_read_port.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_rename_rf_read_port
// Description : One operand read port with commit bypass. Returns the stored
//               value/tag, unless the ROB is committing the exact producer
//               this register is waiting on, in which case the committed
//               value is forwarded and the operand reported ready.
// Ports       : rs            in  source register index
//               reg_val       in  stored value of reg[rs]
//               reg_tag       in  stored tag of reg[rs]
//               commit_valid  in  ROB commit this cycle
//               commit_rd     in  committed destination
//               commit_res    in  committed value
//               commit_dep    in  ROB id of committing entry
//               val           out operand value
//               q             out operand tag (TAG_NONE = ready)
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_rename_rf_read_port
    import reg_file_rename_pkg::*;
(
    input  logic [REG_IDX_W-1:0] rs,
    input  logic [XLEN-1:0]      reg_val,
    input  logic [ROB_IDX_W-1:0] reg_tag,
    input  logic                 commit_valid,
    input  logic [REG_IDX_W-1:0] commit_rd,
    input  logic [XLEN-1:0]      commit_res,
    input  logic [ROB_IDX_W-1:0] commit_dep,
    output logic [XLEN-1:0]      val,
    output logic [ROB_IDX_W-1:0] q
);

    logic w_bypass;

    // Forward only when the commit is the producer this register waits on;
    // a commit from an older producer is superseded by a younger rename.
    assign w_bypass = commit_valid && (commit_rd == rs) && (rs != '0) &&
                      (reg_tag == commit_dep);

    always_comb begin
        val = reg_val;
        q   = reg_tag;
        if (w_bypass) begin
            val = commit_res;
            q   = TAG_NONE;
        end
    end

endmodule : reg_file_rename_rf_read_port
`default_nettype wire

// File: rtl/reg_file_rename.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_rename
// Description : Architectural register file with per-register rename tags.
//               Consumes ROB commits, serves dispatcher renames and two
//               combinational operand reads with commit bypass.
// Ports       : clk, rst_n (sync, active-low), rdy (global enable),
//               flush (clear all tags, drop rename, keep commit),
//               commit_valid/commit_rd/commit_res/commit_dep (ROB commit),
//               rename_valid/rename_rd/rename_rob_id (dispatcher rename),
//               rs1/rs2 -> val1/q1, val2/q2 (combinational reads)
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_rename
    import reg_file_rename_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    input  logic                 flush,
    input  logic                 commit_valid,
    input  logic [REG_IDX_W-1:0] commit_rd,
    input  logic [XLEN-1:0]      commit_res,
    input  logic [ROB_IDX_W-1:0] commit_dep,
    input  logic                 rename_valid,
    input  logic [REG_IDX_W-1:0] rename_rd,
    input  logic [ROB_IDX_W-1:0] rename_rob_id,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic [XLEN-1:0]      val1,
    output logic [XLEN-1:0]      val2,
    output logic [ROB_IDX_W-1:0] q1,
    output logic [ROB_IDX_W-1:0] q2
);

    logic [XLEN-1:0]      r_regs [REG_NUM];
    logic [ROB_IDX_W-1:0] r_tags [REG_NUM];

    logic w_commit_en;
    logic w_rename_en;

    assign w_commit_en = rdy && commit_valid && (commit_rd != '0);
    assign w_rename_en = rdy && rename_valid && (rename_rd != '0) && !flush;

    // Statement order matters: flush clear, then commit tag release, then
    // rename. A later assignment to the same tag wins, so a same-cycle rename
    // overrides the commit's release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= '0;
                r_tags[i] <= TAG_NONE;
            end
        end else if (rdy) begin
            if (flush) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    r_tags[i] <= TAG_NONE;
                end
            end
            if (w_commit_en) begin
                r_regs[commit_rd] <= commit_res;
                // Only release the tag if no younger rename has replaced it.
                if (r_tags[commit_rd] == commit_dep) begin
                    r_tags[commit_rd] <= TAG_NONE;
                end
            end
            if (w_rename_en) begin
                r_tags[rename_rd] <= rename_rob_id;
            end
        end
    end

    reg_file_rename_rf_read_port u_rd_port1 (
        .rs           (rs1),
        .reg_val      (r_regs[rs1]),
        .reg_tag      (r_tags[rs1]),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_res   (commit_res),
        .commit_dep   (commit_dep),
        .val          (val1),
        .q            (q1)
    );

    reg_file_rename_rf_read_port u_rd_port2 (
        .rs           (rs2),
        .reg_val      (r_regs[rs2]),
        .reg_tag      (r_tags[rs2]),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_res   (commit_res),
        .commit_dep   (commit_dep),
        .val          (val2),
        .q            (q2)
    );

endmodule : reg_file_rename
`default_nettype wire

// File: tb/tb_reg_file_rename.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_rename
// Description : Directed self-checking bench for reg_file_rename. Inputs are
//               driven 1 ns after the rising edge; outputs are checked mid
//               cycle against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_rename;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic        flush;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_res;
    logic [4:0]  commit_dep;
    logic        rename_valid;
    logic [4:0]  rename_rd;
    logic [4:0]  rename_rob_id;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] val1;
    logic [31:0] val2;
    logic [4:0]  q1;
    logic [4:0]  q2;

    int total = 0;
    int bad   = 0;

    reg_file_rename dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rdy           (rdy),
        .flush         (flush),
        .commit_valid  (commit_valid),
        .commit_rd     (commit_rd),
        .commit_res    (commit_res),
        .commit_dep    (commit_dep),
        .rename_valid  (rename_valid),
        .rename_rd     (rename_rd),
        .rename_rob_id (rename_rob_id),
        .rs1           (rs1),
        .rs2           (rs2),
        .val1          (val1),
        .val2          (val2),
        .q1            (q1),
        .q2            (q2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        flush        = 1'b0;
        commit_valid = 1'b0;
        commit_rd    = '0;
        commit_res   = '0;
        commit_dep   = '0;
        rename_valid = 1'b0;
        rename_rd    = '0;
        rename_rob_id = '0;
    endtask

    task automatic do_rename(input logic [4:0] rd, input logic [4:0] id);
        rename_valid  = 1'b1;
        rename_rd     = rd;
        rename_rob_id = id;
        tick();
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        rdy   = 1'b1;
        rs1   = '0;
        rs2   = '0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        rs1 = 5'd5; rs2 = 5'd0; settle();
        chk("reset_val1", val1, 32'h0);
        chk("reset_q1",   {27'b0, q1}, 32'h0);
        chk("reset_val2", val2, 32'h0);
        chk("reset_q2",   {27'b0, q2}, 32'h0);

        // Commit to x0 is dropped, and never bypassed
        commit_valid = 1'b1; commit_rd = 5'd0; commit_res = 32'hDEAD; commit_dep = 5'd0;
        rs1 = 5'd0; settle();
        chk("x0_commit_bypass", val1, 32'h0);
        tick(); idle(); settle();
        chk("x0_val_after", val1, 32'h0);
        chk("x0_q_after",   {27'b0, q1}, 32'h0);

        // Rename x3 -> 4, then commit with bypass
        do_rename(5'd3, 5'd4);
        rs1 = 5'd3; settle();
        chk("x3_q_renamed", {27'b0, q1}, 32'd4);
        commit_valid = 1'b1; commit_rd = 5'd3; commit_res = 32'h1234; commit_dep = 5'd4;
        rs2 = 5'd3; settle();
        chk("x3_bypass_val1", val1, 32'h1234);
        chk("x3_bypass_q1",   {27'b0, q1}, 32'd0);
        chk("x3_bypass_val2", val2, 32'h1234);
        tick(); idle(); settle();
        chk("x3_val_after", val1, 32'h1234);
        chk("x3_q_after",   {27'b0, q1}, 32'd0);

        // Younger rename survives older commit
        do_rename(5'd7, 5'd2);
        do_rename(5'd7, 5'd6);
        commit_valid = 1'b1; commit_rd = 5'd7; commit_res = 32'd9; commit_dep = 5'd2;
        rs1 = 5'd7; settle();
        chk("x7_no_bypass_val", val1, 32'h0);
        chk("x7_no_bypass_q",   {27'b0, q1}, 32'd6);
        tick(); idle(); settle();
        chk("x7_val_after", val1, 32'd9);
        chk("x7_q_after",   {27'b0, q1}, 32'd6);

        // Same-cycle commit and rename on x8: rename wins the tag
        do_rename(5'd8, 5'd3);
        commit_valid = 1'b1; commit_rd = 5'd8; commit_res = 32'h88; commit_dep = 5'd3;
        rename_valid = 1'b1; rename_rd = 5'd8; rename_rob_id = 5'd5;
        rs1 = 5'd8; settle();
        chk("x8_same_cycle_val", val1, 32'h88);
        chk("x8_same_cycle_q",   {27'b0, q1}, 32'd0);
        tick(); idle(); settle();
        chk("x8_val_after", val1, 32'h88);
        chk("x8_q_after",   {27'b0, q1}, 32'd5);

        // No rename bypass on read
        rename_valid = 1'b1; rename_rd = 5'd9; rename_rob_id = 5'd7;
        rs1 = 5'd9; settle();
        chk("x9_old_tag", {27'b0, q1}, 32'd0);
        tick(); idle(); settle();
        chk("x9_new_tag", {27'b0, q1}, 32'd7);

        // Flush with concurrent commit and rename
        do_rename(5'd1, 5'd1);
        do_rename(5'd2, 5'd2);
        do_rename(5'd3, 5'd3);
        do_rename(5'd4, 5'd4);
        flush = 1'b1;
        commit_valid = 1'b1; commit_rd = 5'd1; commit_res = 32'h40; commit_dep = 5'd9;
        rename_valid = 1'b1; rename_rd = 5'd5; rename_rob_id = 5'd10;
        rs1 = 5'd2; settle();
        chk("flush_preflush_q", {27'b0, q1}, 32'd2);
        tick(); idle();
        rs1 = 5'd1; rs2 = 5'd5; settle();
        chk("flush_x1_val", val1, 32'h40);
        chk("flush_x5_q",   {27'b0, q2}, 32'd0);
        for (int r = 1; r <= 9; r++) begin
            rs1 = r[4:0]; settle();
            chk($sformatf("flush_tag_x%0d", r), {27'b0, q1}, 32'd0);
        end

        // rdy=0 holds all state
        do_rename(5'd10, 5'd11);
        rdy = 1'b0;
        commit_valid = 1'b1; commit_rd = 5'd10; commit_res = 32'h55; commit_dep = 5'd11;
        rename_valid = 1'b1; rename_rd = 5'd12; rename_rob_id = 5'd13;
        tick(); idle(); rdy = 1'b1;
        rs1 = 5'd10; rs2 = 5'd12; settle();
        chk("hold_x10_val", val1, 32'h0);
        chk("hold_x10_q",   {27'b0, q1}, 32'd11);
        chk("hold_x12_q",   {27'b0, q2}, 32'd0);

        // Reset mid-traffic
        rst_n = 1'b0;
        commit_valid = 1'b1; commit_rd = 5'd10; commit_res = 32'h77; commit_dep = 5'd11;
        rename_valid = 1'b1; rename_rd = 5'd13; rename_rob_id = 5'd14;
        tick(); idle(); rst_n = 1'b1;
        rs1 = 5'd10; rs2 = 5'd13; settle();
        chk("rst_x10_val", val1, 32'h0);
        chk("rst_x10_q",   {27'b0, q1}, 32'd0);
        chk("rst_x13_q",   {27'b0, q2}, 32'd0);
        rs1 = 5'd8; rs2 = 5'd3; settle();
        chk("rst_x8_val", val1, 32'h0);
        chk("rst_x3_val", val2, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reg_file_rename
`default_nettype wire
